rbcp_master: RTL and testbench
==============================

Name: rbcp_master

Overview:
- Initiator side of the SiTCP RBCP register protocol.
- Accepts a burst command (start address, byte count, direction) on a valid/ready interface and issues one RBCP byte cycle per byte. Each cycle waits for RBCP_ACK, with a timeout.
- Streams write bytes in and read bytes out, with backpressure on both.
- Used as a local RBCP host: self-test of RBCP-to-bus bridges, and an on-chip configuration sequencer driving the same register map.

Parameters:
- ACK_TIMEOUT, 255: cycles to wait for RBCP_ACK after a strobe before aborting; legal range 1..65535.
- ACT_SETUP, 1: cycles RBCP_ACT is high before the first strobe; legal range 1..15.

Ports:
- BUS_CLK  in  1  clock
- BUS_RST  in  1  reset; synchronous, active-high
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY
- CMD_WRITE  in  1  1=write burst, 0=read burst
- CMD_ADDR  in  32  start address
- CMD_LEN  in  8  byte count; 0 means 256
- WR_DATA  in  8  write byte
- WR_VALID  in  1  write byte available
- WR_READY  out  1  write byte consumed when WR_VALID & WR_READY
- RD_DATA  out  8  read byte
- RD_VALID  out  1  read byte available
- RD_READY  in  1  read byte consumed
- DONE  out  1  one-cycle pulse at burst end
- ERROR  out  1  valid with DONE; 1 = burst aborted on timeout
- RBCP_ACT  out  1  transaction active
- RBCP_ADDR  out  32  byte address
- RBCP_WD  out  8  write byte
- RBCP_WE  out  1  write strobe, one cycle
- RBCP_RE  out  1  read strobe, one cycle
- RBCP_ACK  in  1  responder acknowledge, one cycle
- RBCP_RD  in  8  read byte, valid while RBCP_ACK=1

Behaviour:
- Reset values: all outputs 0 except CMD_READY=1. BUS_RST in any state returns to IDLE on the next edge and drops RBCP_ACT immediately. No DONE pulse is issued for the aborted burst. A held read byte is discarded.
- All outputs are registered.
- IDLE: CMD_READY=1. On handshake:
  - latch address, direction and remaining count (CMD_LEN 0 loads 256, 9-bit counter);
  - set RBCP_ACT;
  - go to SETUP.
- SETUP: hold for ACT_SETUP cycles. Then go to FETCH (write) or STROBE (read).
- FETCH: WR_READY=1. On WR_VALID, latch WR_DATA into RBCP_WD and go to STROBE. This state is skipped when a write byte was already latched.
- STROBE: pulse RBCP_WE or RBCP_RE for exactly one cycle, with RBCP_ADDR/RBCP_WD stable. Clear the timer. Go to WAIT_ACK.
- WAIT_ACK:
  - Timer counts each cycle.
  - On RBCP_ACK for a read: capture RBCP_RD, assert RD_VALID, go to DELIVER.
  - On RBCP_ACK for a write: decrement count and increment address.
  - If count reaches 0, go to FINISH.
  - Otherwise, for writes, WR_READY is asserted in the ACK cycle. If WR_VALID is present, the next byte is latched and the FSM goes straight to STROBE; else it goes to FETCH.
  - Timer reaching ACK_TIMEOUT with no ACK: set the error flag and go to FINISH.
- Throughput: 2 cycles/byte when the responder ACKs on the cycle after the strobe and the data stream is not stalled.
- DELIVER: hold RD_DATA and RD_VALID until RD_READY. Then decrement and increment, and go to STROBE, or to FINISH when the count reaches 0.
- FINISH:
  - drop RBCP_ACT;
  - pulse DONE;
  - drive ERROR from the error flag, then clear the flag;
  - return to IDLE.
  - The next command is accepted at the earliest one cycle after DONE, so RBCP_ACT is low for at least 1 cycle between bursts.
- Address increments modulo 2^32: 0xFFFFFFFF is followed by 0x00000000.
- RBCP_ACK outside WAIT_ACK is ignored.
- RBCP_ACK in the same cycle as the timeout counts as an ACK, not an error.
- A write burst never reads WR_DATA beyond CMD_LEN bytes.
- No WE/RE strobe is issued after a timeout.

Decomposition:
- Package rbcp_pkg holds:
  - FSM state enum: IDLE, SETUP, FETCH, STROBE, WAIT_ACK, DELIVER, FINISH;
  - RBCP width constants: address 32, data 8;
  - length-zero-means-256 constant.
- One sub-module, rbcp_ack_timer: a 16-bit clearable counter with a timeout flag.

Test Plan:
- Write 1 byte, 0xA5 to 0x00001000, with a stub responder that ACKs 1 cycle after the strobe -> a single WE with ADDR 0x1000, WD 0xA5; DONE=1 and ERROR=0; RBCP_ACT high for ACT_SETUP+3 cycles.
- Read 4 bytes from 0x20, stub returns address LSB, RD_READY=1 -> RD_DATA sequence 0x20, 0x21, 0x22, 0x23; 4 RE strobes; DONE once.
- Read 2 bytes with RD_READY held low for 10 cycles -> second RE is not issued until the first byte is consumed; data intact.
- Write with a responder that never ACKs, ACK_TIMEOUT=8 -> one WE strobe, DONE and ERROR=1 exactly 8 cycles after WAIT_ACK entry; no further WE; RBCP_ACT low.
- CMD_LEN=0 write starting at 0xFFFFFFFF -> 256 WE strobes with addresses 0xFFFFFFFF, 0x0, ..., 0xFE; exactly 256 WR handshakes.
- BUS_RST asserted mid-read at byte 2 of 4 -> next edge: RBCP_ACT=0, RD_VALID=0, CMD_READY=1, no DONE pulse; a new command then runs normally.

Source files
------------

// File: rtl/rbcp_pkg.sv
// Shared FSM type, bus widths and length helper for the RBCP initiator.
package rbcp_pkg;

    localparam int RBCP_ADDR_W = 32;
    localparam int RBCP_DATA_W = 8;
    localparam int RBCP_CNT_W  = 9;

    localparam logic [RBCP_CNT_W-1:0] RBCP_LEN_ZERO_BYTES = 9'd256;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        FETCH    = 3'd2,
        STROBE   = 3'd3,
        WAIT_ACK = 3'd4,
        DELIVER  = 3'd5,
        FINISH   = 3'd6
    } rbcp_state_e;

    // A length field of zero encodes a full 256-byte burst.
    function automatic logic [RBCP_CNT_W-1:0] rbcp_len_to_count(input logic [RBCP_DATA_W-1:0] len);
        logic [RBCP_CNT_W-1:0] cnt;
        if (len == 8'd0) begin
            cnt = RBCP_LEN_ZERO_BYTES;
        end else begin
            cnt = {1'b0, len};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rbcp_master_if.sv
// Command, byte-stream and RBCP bus signals of the initiator; master = initiator side.
interface rbcp_master_if;
    import rbcp_pkg::*;

    logic                   CMD_VALID;
    logic                   CMD_READY;
    logic                   CMD_WRITE;
    logic [RBCP_ADDR_W-1:0] CMD_ADDR;
    logic [RBCP_DATA_W-1:0] CMD_LEN;
    logic [RBCP_DATA_W-1:0] WR_DATA;
    logic                   WR_VALID;
    logic                   WR_READY;
    logic [RBCP_DATA_W-1:0] RD_DATA;
    logic                   RD_VALID;
    logic                   RD_READY;
    logic                   DONE;
    logic                   ERROR;
    logic                   RBCP_ACT;
    logic [RBCP_ADDR_W-1:0] RBCP_ADDR;
    logic [RBCP_DATA_W-1:0] RBCP_WD;
    logic                   RBCP_WE;
    logic                   RBCP_RE;
    logic                   RBCP_ACK;
    logic [RBCP_DATA_W-1:0] RBCP_RD;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_LEN, WR_DATA, WR_VALID, RD_READY,
               RBCP_ACK, RBCP_RD,
        output CMD_READY, WR_READY, RD_DATA, RD_VALID, DONE, ERROR,
               RBCP_ACT, RBCP_ADDR, RBCP_WD, RBCP_WE, RBCP_RE
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_LEN, WR_DATA, WR_VALID, RD_READY,
               RBCP_ACK, RBCP_RD,
        input  CMD_READY, WR_READY, RD_DATA, RD_VALID, DONE, ERROR,
               RBCP_ACT, RBCP_ADDR, RBCP_WD, RBCP_WE, RBCP_RE
    );

endinterface

// File: rtl/rbcp_ack_timer.sv
// Clearable 16-bit wait counter; flags the TIMEOUT-th enabled cycle since the last clear.
module rbcp_ack_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear wins, then saturating increment while enabled.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 16'd0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = en_i && (count_q == LAST);

endmodule

// File: rtl/rbcp_master.sv
// RBCP initiator: turns a burst command into one RBCP byte cycle per byte with ACK timeout.
module rbcp_master
    import rbcp_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int ACT_SETUP   = 1
) (
    input  logic          BUS_CLK,
    input  logic          BUS_RST,
    rbcp_master_if.master bus
);

    localparam logic [3:0] SETUP_LAST = 4'(ACT_SETUP - 1);

    rbcp_state_e            state_q, state_d;
    logic [RBCP_ADDR_W-1:0] addr_q, addr_d;
    logic [RBCP_CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]             setup_q, setup_d;
    logic                   write_q, write_d;
    logic                   err_q, err_d;
    logic                   have_nxt_q, have_nxt_d;
    logic [RBCP_DATA_W-1:0] wd_q, wd_d;
    logic [RBCP_DATA_W-1:0] nxt_wd_q, nxt_wd_d;
    logic [RBCP_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   wr_ready_q, wr_ready_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   act_q, act_d;
    logic                   we_q, we_d;
    logic                   re_q, re_d;
    logic                   cmd_hs_s, wr_hs_s, rd_hs_s;
    logic                   tmr_clr_s, tmr_en_s, tmr_timeout_s;

    assign cmd_hs_s  = bus.CMD_VALID & cmd_ready_q;
    assign wr_hs_s   = bus.WR_VALID & wr_ready_q;
    assign rd_hs_s   = rd_valid_q & bus.RD_READY;
    assign tmr_clr_s = (state_q == STROBE);
    assign tmr_en_s  = (state_q == WAIT_ACK);

    rbcp_ack_timer #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk_i     (BUS_CLK),
        .rst_i     (BUS_RST),
        .clr_i     (tmr_clr_s),
        .en_i      (tmr_en_s),
        .timeout_o (tmr_timeout_s)
    );

    // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        setup_d    = setup_q;
        write_d    = write_q;
        err_d      = err_q;
        have_nxt_d = have_nxt_q;
        wd_d       = wd_q;
        nxt_wd_d   = nxt_wd_q;
        rd_data_d  = rd_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_hs_s) begin
                    addr_d     = bus.CMD_ADDR;
                    write_d    = bus.CMD_WRITE;
                    cnt_d      = rbcp_len_to_count(bus.CMD_LEN);
                    setup_d    = 4'd0;
                    err_d      = 1'b0;
                    have_nxt_d = 1'b0;
                    state_d    = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (setup_q == SETUP_LAST) begin
                    if (write_q) begin
                        state_d = FETCH;
                    end else begin
                        state_d = STROBE;
                    end
                end else begin
                    setup_d = setup_q + 4'd1;
                end
            end
            FETCH: begin
                if (wr_hs_s) begin
                    wd_d    = bus.WR_DATA;
                    state_d = STROBE;
                end else begin
                    state_d = FETCH;
                end
            end
            STROBE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Prefetch the next write byte while waiting so back-to-back bytes cost two cycles.
                if (wr_hs_s) begin
                    nxt_wd_d   = bus.WR_DATA;
                    have_nxt_d = 1'b1;
                end else begin
                    nxt_wd_d = nxt_wd_q;
                end
                if (bus.RBCP_ACK) begin
                    if (write_q) begin
                        cnt_d  = cnt_q - 9'd1;
                        addr_d = addr_q + 32'd1;
                        if (cnt_q == 9'd1) begin
                            state_d = FINISH;
                        end else if (have_nxt_q) begin
                            wd_d       = nxt_wd_q;
                            have_nxt_d = 1'b0;
                            state_d    = STROBE;
                        end else if (wr_hs_s) begin
                            wd_d       = bus.WR_DATA;
                            have_nxt_d = 1'b0;
                            state_d    = STROBE;
                        end else begin
                            state_d = FETCH;
                        end
                    end else begin
                        rd_data_d = bus.RBCP_RD;
                        state_d   = DELIVER;
                    end
                end else if (tmr_timeout_s) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            DELIVER: begin
                if (rd_hs_s) begin
                    cnt_d  = cnt_q - 9'd1;
                    addr_d = addr_q + 32'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = FINISH;
                    end else begin
                        state_d = STROBE;
                    end
                end else begin
                    state_d = DELIVER;
                end
            end
            FINISH: begin
                err_d      = 1'b0;
                have_nxt_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        act_d       = (state_d == SETUP) || (state_d == FETCH) || (state_d == STROBE) ||
                      (state_d == WAIT_ACK) || (state_d == DELIVER);
        we_d        = (state_d == STROBE) && write_d;
        re_d        = (state_d == STROBE) && !write_d;
        rd_valid_d  = (state_d == DELIVER);
        done_d      = (state_d == FINISH);
        error_d     = (state_d == FINISH) && err_d;
        wr_ready_d  = (state_d == FETCH) ||
                      ((state_d == WAIT_ACK) && write_d && (cnt_d > 9'd1) && !have_nxt_d);
    end

    // State and registered outputs.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            cnt_q       <= 9'd0;
            setup_q     <= 4'd0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            have_nxt_q  <= 1'b0;
            wd_q        <= 8'd0;
            nxt_wd_q    <= 8'd0;
            rd_data_q   <= 8'd0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            act_q       <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            setup_q     <= setup_d;
            write_q     <= write_d;
            err_q       <= err_d;
            have_nxt_q  <= have_nxt_d;
            wd_q        <= wd_d;
            nxt_wd_q    <= nxt_wd_d;
            rd_data_q   <= rd_data_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
            act_q       <= act_d;
            we_q        <= we_d;
            re_q        <= re_d;
        end
    end

    assign bus.CMD_READY = cmd_ready_q;
    assign bus.WR_READY  = wr_ready_q;
    assign bus.RD_DATA   = rd_data_q;
    assign bus.RD_VALID  = rd_valid_q;
    assign bus.DONE      = done_q;
    assign bus.ERROR     = error_q;
    assign bus.RBCP_ACT  = act_q;
    assign bus.RBCP_ADDR = addr_q;
    assign bus.RBCP_WD   = wd_q;
    assign bus.RBCP_WE   = we_q;
    assign bus.RBCP_RE   = re_q;

endmodule

// File: tb/tb_rbcp_master.sv
// Directed and randomized bursts against a stub RBCP responder and a byte-level reference model.
module tb_rbcp_master;

    localparam int TB_TIMEOUT = 8;
    localparam int TB_SETUP   = 2;

    logic clk = 1'b0;
    logic rst;

    rbcp_master_if bus ();

    rbcp_master #(
        .ACK_TIMEOUT (TB_TIMEOUT),
        .ACT_SETUP   (TB_SETUP)
    ) dut (
        .BUS_CLK (clk),
        .BUS_RST (rst),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [31:0] we_addr [$];
    logic [7:0]  we_data [$];
    int          we_cyc  [$];
    logic [31:0] re_addr [$];
    int          re_cyc  [$];
    logic [7:0]  rd_got  [$];
    int          rd_hs_cyc [$];
    logic [7:0]  wr_src  [$];
    int          wr_hs, done_cnt, done_cyc, act_cycles;
    logic        last_err;

    int   ack_dmin = 1, ack_dmax = 1;
    bit   resp_on = 1'b1;
    logic [7:0] rd_xor = 8'h00;
    int   wr_stall_pct = 0, rd_stall_pct = 0, rd_hold = 0, rd_limit = 1000000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter advanced on the active edge; everything else samples on the falling edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus monitor.
    initial forever begin
        @(negedge clk);
        if (bus.RBCP_WE) begin
            we_addr.push_back(bus.RBCP_ADDR);
            we_data.push_back(bus.RBCP_WD);
            we_cyc.push_back(cyc);
        end
        if (bus.RBCP_RE) begin
            re_addr.push_back(bus.RBCP_ADDR);
            re_cyc.push_back(cyc);
        end
        if (bus.DONE) begin
            done_cnt++;
            last_err = bus.ERROR;
            done_cyc = cyc;
        end
        if (bus.RBCP_ACT) act_cycles++;
    end

    // Stub responder: ACK d cycles after a strobe, read data = address LSB ^ rd_xor.
    initial begin
        int pend;
        logic [7:0] rdv;
        pend = 0;
        rdv = 8'h00;
        bus.RBCP_ACK = 1'b0;
        bus.RBCP_RD  = 8'h00;
        forever begin
            @(negedge clk);
            bus.RBCP_ACK = 1'b0;
            bus.RBCP_RD  = 8'($urandom);
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.RBCP_ACK = 1'b1;
                    bus.RBCP_RD  = rdv;
                end
            end
            if ((bus.RBCP_WE || bus.RBCP_RE) && resp_on) begin
                pend = int'($urandom_range(ack_dmax, ack_dmin));
                rdv  = bus.RBCP_ADDR[7:0] ^ rd_xor;
            end
            if (rst) pend = 0;
        end
    end

    // Write-byte source.
    initial begin
        bus.WR_VALID = 1'b0;
        bus.WR_DATA  = 8'h00;
        forever begin
            @(negedge clk);
            if ((wr_src.size() > 0) && (int'($urandom_range(99)) >= wr_stall_pct)) begin
                bus.WR_VALID = 1'b1;
                bus.WR_DATA  = wr_src[0];
            end else begin
                bus.WR_VALID = 1'b0;
                bus.WR_DATA  = 8'($urandom);
            end
            if (bus.WR_VALID && bus.WR_READY) begin
                void'(wr_src.pop_front());
                wr_hs++;
            end
        end
    end

    // Read-byte sink.
    initial begin
        bus.RD_READY = 1'b0;
        forever begin
            @(negedge clk);
            if ((rd_hold > 0) && bus.RD_VALID) begin
                bus.RD_READY = 1'b0;
                rd_hold--;
            end else if (rd_got.size() >= rd_limit) begin
                bus.RD_READY = 1'b0;
            end else begin
                bus.RD_READY = (int'($urandom_range(99)) >= rd_stall_pct);
            end
            if (bus.RD_READY && bus.RD_VALID) begin
                rd_got.push_back(bus.RD_DATA);
                rd_hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        we_addr.delete(); we_data.delete(); we_cyc.delete();
        re_addr.delete(); re_cyc.delete();
        rd_got.delete(); rd_hs_cyc.delete(); wr_src.delete();
        wr_hs = 0; done_cnt = 0; done_cyc = 0; act_cycles = 0; last_err = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] l);
        int n;
        n = 0;
        @(negedge clk);
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = w;
        bus.CMD_ADDR  = a;
        bus.CMD_LEN   = l;
        while (!bus.CMD_READY && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", {31'd0, bus.CMD_READY}, 32'd1);
        @(negedge clk);
        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = 1'($urandom);
        bus.CMD_ADDR  = $urandom;
        bus.CMD_LEN   = 8'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((done_cnt == 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", {31'd0, (done_cnt != 0)}, 32'd1);
    endtask

    // Run one burst and compare every strobe and byte against the address/stream model.
    task automatic run_burst(input bit w, input logic [31:0] a, input int n, input string tag,
                             input int first_byte);
        logic [7:0]  bytes [$];
        logic [31:0] ea;
        clear_logs();
        for (int i = 0; i < n + 4; i++) bytes.push_back(8'($urandom));
        if (first_byte >= 0) bytes[0] = 8'(first_byte);
        if (w) wr_src = bytes;
        issue(w, a, 8'(n));
        wait_done(8000);
        @(negedge clk);
        chk({tag, "/done_count"}, done_cnt, 32'd1);
        chk({tag, "/error"}, {31'd0, last_err}, 32'd0);
        if (w) begin
            chk({tag, "/we_count"}, we_addr.size(), n);
            chk({tag, "/wr_handshakes"}, wr_hs, n);
            chk({tag, "/re_count"}, re_addr.size(), 32'd0);
            for (int i = 0; (i < n) && (i < we_addr.size()); i++) begin
                ea = a + 32'(i);
                chk({tag, "/we_addr"}, we_addr[i], ea);
                chk({tag, "/we_data"}, {24'd0, we_data[i]}, {24'd0, bytes[i]});
            end
        end else begin
            chk({tag, "/re_count"}, re_addr.size(), n);
            chk({tag, "/rd_count"}, rd_got.size(), n);
            chk({tag, "/we_count"}, we_addr.size(), 32'd0);
            for (int i = 0; (i < n) && (i < re_addr.size()) && (i < rd_got.size()); i++) begin
                ea = a + 32'(i);
                chk({tag, "/re_addr"}, re_addr[i], ea);
                chk({tag, "/rd_data"}, {24'd0, rd_got[i]}, {24'd0, ea[7:0] ^ rd_xor});
            end
        end
    endtask

    initial begin
        int n;
        int d0;
        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = 32'd0;
        bus.CMD_LEN   = 8'd0;
        clear_logs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst/cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
        chk("rst/act", {31'd0, bus.RBCP_ACT}, 32'd0);
        chk("rst/we_re", {30'd0, bus.RBCP_WE, bus.RBCP_RE}, 32'd0);
        chk("rst/wr_ready", {31'd0, bus.WR_READY}, 32'd0);
        chk("rst/rd_valid", {31'd0, bus.RD_VALID}, 32'd0);
        chk("rst/done_error", {30'd0, bus.DONE, bus.ERROR}, 32'd0);
        chk("rst/addr", bus.RBCP_ADDR, 32'd0);
        chk("rst/data", {16'd0, bus.RBCP_WD, bus.RD_DATA}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_burst(1'b1, 32'h0000_1000, 1, "wr1", 8'hA5);
        chk("wr1/act_cycles", act_cycles, TB_SETUP + 3);

        run_burst(1'b0, 32'h0000_0020, 4, "rd4", -1);

        rd_hold = 10;
        run_burst(1'b0, 32'h0000_0030, 2, "rd_hold", -1);
        chk("rd_hold/re2_after_consume",
            {31'd0, (re_cyc.size() > 1) && (rd_hs_cyc.size() > 0) && (re_cyc[1] > rd_hs_cyc[0])}, 32'd1);
        chk("rd_hold/byte_held",
            {31'd0, (rd_hs_cyc.size() > 0) && (re_cyc.size() > 0) && (rd_hs_cyc[0] - re_cyc[0] >= 10)}, 32'd1);

        run_burst(1'b1, 32'h0000_0100, 4, "thru", -1);
        for (int i = 0; (i < 3) && (i + 1 < we_cyc.size()); i++)
            chk("thru/two_cycles_per_byte", we_cyc[i+1] - we_cyc[i], 32'd2);

        ack_dmin = TB_TIMEOUT;
        ack_dmax = TB_TIMEOUT;
        run_burst(1'b1, 32'h0000_5000, 2, "ack_at_limit", -1);
        ack_dmin = 1;
        ack_dmax = 1;

        clear_logs();
        resp_on = 1'b0;
        for (int i = 0; i < 3; i++) wr_src.push_back(8'($urandom));
        issue(1'b1, 32'h0000_3000, 8'd3);
        wait_done(300);
        @(negedge clk);
        chk("tmo/error", {31'd0, last_err}, 32'd1);
        chk("tmo/done_delay", (we_cyc.size() > 0) ? (done_cyc - we_cyc[0]) : -1, TB_TIMEOUT + 1);
        repeat (20) @(negedge clk);
        chk("tmo/we_count", we_addr.size(), 32'd1);
        chk("tmo/done_count", done_cnt, 32'd1);
        chk("tmo/act_low", {31'd0, bus.RBCP_ACT}, 32'd0);
        resp_on = 1'b1;

        ack_dmin = 1;
        ack_dmax = 3;
        wr_stall_pct = 20;
        run_burst(1'b1, 32'hFFFF_FFFF, 256, "len256", -1);
        wr_stall_pct = 0;
        ack_dmax = 1;

        clear_logs();
        rd_limit = 1;
        issue(1'b0, 32'h0000_0040, 8'd4);
        n = 0;
        while (!((re_addr.size() == 2) && bus.RD_VALID) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        chk("midrst/second_byte_held", {31'd0, (re_addr.size() == 2) && bus.RD_VALID}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst/act", {31'd0, bus.RBCP_ACT}, 32'd0);
        chk("midrst/rd_valid", {31'd0, bus.RD_VALID}, 32'd0);
        chk("midrst/cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        chk("midrst/no_done", done_cnt, d0);
        chk("midrst/no_more_re", re_addr.size(), 32'd2);
        rd_limit = 1000000;
        run_burst(1'b0, 32'h0000_0080, 2, "post_rst", -1);

        wr_stall_pct = 30;
        rd_stall_pct = 30;
        ack_dmax = 4;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            a = ($urandom_range(1) == 1) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
            rd_xor = 8'($urandom);
            run_burst(1'($urandom_range(1)), a, int'($urandom_range(24, 1)), "rand", -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
